// File: rtl/image_pkg.sv
// Shared types and constants for the image buffer arbiter: FSM states, owner codes, default geometry.
package image_pkg;

  localparam int COL_W_DEF  = 4;
  localparam int ROW_W_DEF  = 4;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    READ_ISSUE = 2'd2,
    READ_DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_WR   = 2'd1;
  localparam logic [1:0] OWN_RD   = 2'd2;

  function automatic logic [1:0] state_owner(input state_t s);
    logic [1:0] o;
    case (s)
      IDLE:       o = OWN_NONE;
      WRITE:      o = OWN_WR;
      READ_ISSUE: o = OWN_RD;
      READ_DRAIN: o = OWN_RD;
      default:    o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/image_frame_arbiter_if.sv
// Loader, renderer and RAM signal bundle; master is the arbiter side, slave the surrounding system.
interface image_frame_arbiter_if #(
  parameter int COL_W  = image_pkg::COL_W_DEF,
  parameter int ROW_W  = image_pkg::ROW_W_DEF,
  parameter int DATA_W = image_pkg::DATA_W_DEF
);
  logic                    wr_req;
  logic                    wr_valid;
  logic [DATA_W-1:0]       wr_data;
  logic                    wr_ready;
  logic                    rd_req;
  logic                    rd_valid;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_last;
  logic                    rd_ready;
  logic [COL_W+ROW_W-1:0]  mem_addr;
  logic                    mem_we;
  logic                    mem_re;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  modport master (
    input  wr_req, wr_valid, wr_data, rd_req, rd_ready, mem_rdata,
    output wr_ready, rd_valid, rd_data, rd_last, mem_addr, mem_we, mem_re, mem_wdata
  );

  modport slave (
    output wr_req, wr_valid, wr_data, rd_req, rd_ready, mem_rdata,
    input  wr_ready, rd_valid, rd_data, rd_last, mem_addr, mem_we, mem_re, mem_wdata
  );
endinterface

// File: rtl/raster_counter.sv
// Raster scan position {row, col}; col advances every step, row when col wraps.
module raster_counter
  import image_pkg::*;
#(
  parameter int COL_W = COL_W_DEF,
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             at_last
);

  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;

  // Scan position register; both fields wrap to zero together after the last pixel.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col_r <= {COL_W{1'b0}};
      row_r <= {ROW_W{1'b0}};
    end else if (advance) begin
      col_r <= col_r + COL_W'(1);
      if (&col_r) begin
        row_r <= row_r + ROW_W'(1);
      end
    end
  end

  // Position outputs and last-pixel flag.
  always_comb begin
    col     = col_r;
    row     = row_r;
    at_last = (&col_r) & (&row_r);
  end

endmodule

// File: rtl/image_frame_arbiter.sv
// Frame-granular round-robin arbiter for the shared image RAM: raster write/read sequencing,
// with a 2-entry fall-through output FIFO absorbing the one-cycle RAM read latency.
module image_frame_arbiter
  import image_pkg::*;
#(
  parameter int COL_W  = COL_W_DEF,
  parameter int ROW_W  = ROW_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  image_frame_arbiter_if.master bus,
  output logic [1:0]            owner,
  output logic                  frame_done
);

  state_t            state_r, state_nx_s;
  logic [1:0]        last_owner_r, last_owner_nx_s;
  logic              frame_done_r, done_s;

  logic [COL_W-1:0]  col_s;
  logic [ROW_W-1:0]  row_s;
  logic              at_last_s, cnt_clear_s, cnt_adv_s;

  logic              beat_s, issue_s, pop_s, pop_fifo_s, push_fifo_s;
  logic              fifo_empty_s, rd_valid_s;
  logic [1:0]        in_use_s, fifo_cnt_r, fifo_cnt_nx_s;
  logic [DATA_W-1:0] fifo_data_r [2];
  logic [1:0]        fifo_last_r;
  logic              fifo_head_r, fifo_tail_r;
  logic              inflight_r, inflight_last_r;

  raster_counter #(.COL_W(COL_W), .ROW_W(ROW_W)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear_s),
    .advance (cnt_adv_s),
    .col     (col_s),
    .row     (row_s),
    .at_last (at_last_s)
  );

  // Beat, issue and FIFO bookkeeping; a read is issued only if its data is guaranteed a slot.
  always_comb begin
    beat_s        = (state_r == WRITE) && bus.wr_valid;
    fifo_empty_s  = (fifo_cnt_r == 2'd0);
    rd_valid_s    = !fifo_empty_s || inflight_r;
    pop_s         = rd_valid_s && bus.rd_ready;
    in_use_s      = fifo_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
    issue_s       = (state_r == READ_ISSUE) && (in_use_s < 2'd2);
    push_fifo_s   = inflight_r && !(fifo_empty_s && pop_s);
    pop_fifo_s    = pop_s && !fifo_empty_s;
    fifo_cnt_nx_s = fifo_cnt_r + {1'b0, push_fifo_s} - {1'b0, pop_fifo_s};
    cnt_clear_s   = (state_r == IDLE);
    cnt_adv_s     = beat_s || issue_s;
  end

  // Next-state logic; requests matter only in IDLE, ties go to the non-previous owner.
  always_comb begin
    state_nx_s      = state_r;
    last_owner_nx_s = last_owner_r;
    done_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.wr_req && bus.rd_req) begin
          state_nx_s = (last_owner_r == OWN_RD) ? WRITE : READ_ISSUE;
        end else if (bus.wr_req) begin
          state_nx_s = WRITE;
        end else if (bus.rd_req) begin
          state_nx_s = READ_ISSUE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WRITE: begin
        if (beat_s && at_last_s) begin
          state_nx_s      = IDLE;
          last_owner_nx_s = OWN_WR;
          done_s          = 1'b1;
        end else begin
          state_nx_s = WRITE;
        end
      end
      READ_ISSUE: begin
        if (issue_s && at_last_s) begin
          state_nx_s = READ_DRAIN;
        end else begin
          state_nx_s = READ_ISSUE;
        end
      end
      READ_DRAIN: begin
        if (fifo_cnt_nx_s == 2'd0) begin
          state_nx_s      = IDLE;
          last_owner_nx_s = OWN_RD;
          done_s          = 1'b1;
        end else begin
          state_nx_s = READ_DRAIN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // FSM state, round-robin memory and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_owner_r <= OWN_RD;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      last_owner_r <= last_owner_nx_s;
      frame_done_r <= done_s;
    end
  end

  // Read return path: in-flight tag and the two buffered pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_data_r[0]  <= {DATA_W{1'b0}};
      fifo_data_r[1]  <= {DATA_W{1'b0}};
      fifo_last_r     <= 2'b00;
      fifo_head_r     <= 1'b0;
      fifo_tail_r     <= 1'b0;
      fifo_cnt_r      <= 2'd0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      if (push_fifo_s) begin
        fifo_data_r[fifo_tail_r] <= bus.mem_rdata;
        fifo_last_r[fifo_tail_r] <= inflight_last_r;
        fifo_tail_r              <= ~fifo_tail_r;
      end
      if (pop_fifo_s) begin
        fifo_head_r <= ~fifo_head_r;
      end
      fifo_cnt_r      <= fifo_cnt_nx_s;
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s && at_last_s;
    end
  end

  // Output drive; an empty FIFO lets the returning RAM word straight through.
  always_comb begin
    bus.wr_ready  = (state_r == WRITE);
    bus.mem_we    = beat_s;
    bus.mem_re    = issue_s;
    bus.mem_addr  = {row_s, col_s};
    bus.mem_wdata = beat_s ? bus.wr_data : {DATA_W{1'b0}};
    bus.rd_valid  = rd_valid_s;
    bus.rd_data   = {DATA_W{1'b0}};
    bus.rd_last   = 1'b0;
    if (!fifo_empty_s) begin
      bus.rd_data = fifo_data_r[fifo_head_r];
      bus.rd_last = fifo_last_r[fifo_head_r];
    end else if (inflight_r) begin
      bus.rd_data = bus.mem_rdata;
      bus.rd_last = inflight_last_r;
    end else begin
      bus.rd_data = {DATA_W{1'b0}};
      bus.rd_last = 1'b0;
    end
    owner      = state_owner(state_r);
    frame_done = frame_done_r;
  end

endmodule
